// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU data port, the DMA/debug port and dmem.
// slave: the arbiter's view; master: the surrounding requesters + memory.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_cs;
   logic              cpu_r;
   logic              cpu_w;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic [DATA_W-1:0] dma_rdata;
   logic              dma_ack;

   logic              mem_cs;
   logic              mem_r;
   logic              mem_w;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_cs, cpu_r, cpu_w, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_rdata, dma_ack,
      output mem_cs, mem_r, mem_w, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_cs, cpu_r, cpu_w, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_rdata, dma_ack,
      input  mem_cs, mem_r, mem_w, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: CPU has priority, DMA is guaranteed progress by a
// starvation counter that forces a bounded DMA burst.
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4,
   parameter int BURST    = 4
) (
   input  logic           clk_in,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);
   localparam logic [3:0] LP_BURST    = 4'(BURST);

   typedef enum logic {CPU_PRI, DMA_BURST} mode_t;

   mode_t             r_mode;
   mode_t             w_mode_nxt;
   logic [3:0]        r_wait_cnt;
   logic [3:0]        r_burst_cnt;
   logic [3:0]        w_wait_nxt;
   logic [3:0]        w_burst_nxt;
   logic [3:0]        w_wait_eff;
   logic              w_burst_go;
   logic              w_gnt_cpu;
   logic              w_gnt_dma;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;

   // State register: mode and both counters, synchronous active-low reset.
   always_ff @(posedge clk_in) begin
      if (!reset) begin
         r_mode      <= CPU_PRI;
         r_wait_cnt  <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_mode      <= w_mode_nxt;
         r_wait_cnt  <= w_wait_nxt;
         r_burst_cnt <= w_burst_nxt;
      end
   end

   // Next-state and grant decision; an ended burst falls back to CPU-priority
   // arbitration with the wait counter treated as zero for this cycle.
   always_comb begin
      w_gnt_cpu   = 1'b0;
      w_gnt_dma   = 1'b0;
      w_mode_nxt  = CPU_PRI;
      w_wait_nxt  = '0;
      w_burst_nxt = '0;
      w_burst_go  = (r_mode == DMA_BURST) && bus.dma_req && (r_burst_cnt < LP_BURST);
      w_wait_eff  = (r_mode == CPU_PRI) ? r_wait_cnt : '0;
      if (w_burst_go) begin
         w_gnt_dma   = 1'b1;
         w_mode_nxt  = DMA_BURST;
         w_burst_nxt = r_burst_cnt + 4'd1;
      end else if (bus.cpu_cs && !bus.dma_req) begin
         w_gnt_cpu = 1'b1;
      end else if (!bus.cpu_cs && bus.dma_req) begin
         w_gnt_dma = 1'b1;
      end else if (bus.cpu_cs && bus.dma_req) begin
         if (w_wait_eff < LP_MAX_WAIT) begin
            w_gnt_cpu  = 1'b1;
            w_wait_nxt = w_wait_eff + 4'd1;
         end else begin
            w_gnt_dma   = 1'b1;
            w_mode_nxt  = DMA_BURST;
            w_burst_nxt = 4'd1;
         end
      end
   end

   // Output routing from the grant; everything idles while reset is low.
   always_comb begin
      bus.mem_cs    = 1'b0;
      bus.mem_r     = 1'b0;
      bus.mem_w     = 1'b0;
      w_mem_addr    = '0;
      w_mem_wdata   = '0;
      bus.cpu_rdata = '0;
      bus.dma_rdata = '0;
      bus.cpu_stall = 1'b0;
      bus.dma_ack   = 1'b0;
      if (reset) begin
         if (w_gnt_cpu) begin
            bus.mem_cs    = 1'b1;
            bus.mem_r     = bus.cpu_r;
            bus.mem_w     = bus.cpu_w;
            w_mem_addr    = bus.cpu_addr;
            w_mem_wdata   = bus.cpu_wdata;
            bus.cpu_rdata = bus.mem_rdata;
         end else if (w_gnt_dma) begin
            bus.mem_cs    = 1'b1;
            bus.mem_r     = ~bus.dma_we;
            bus.mem_w     = bus.dma_we;
            w_mem_addr    = bus.dma_addr;
            w_mem_wdata   = bus.dma_wdata;
            bus.dma_rdata = bus.mem_rdata;
            bus.dma_ack   = 1'b1;
            bus.cpu_stall = bus.cpu_cs;
         end
      end
   end

   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: main instance (MAX_WAIT=4, BURST=4) with a
// small behavioural dmem, plus a MAX_WAIT=2, BURST=1 instance.
module tb_dmem_arbiter;

   logic clk;
   logic reset;
   int   n_pass;
   int   n_total;

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .BURST(4)) dut (
      .clk_in (clk),
      .reset  (reset),
      .bus    (bus.slave)
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(2), .BURST(1)) dut1 (
      .clk_in (clk),
      .reset  (reset),
      .bus    (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural dmem: combinational read, write at clock edge, preloaded
   // with C0DE_00xx on the first edge.
   logic [31:0] mem [0:255];
   logic        preloaded = 1'b0;
   always @(posedge clk) begin
      if (!preloaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
         preloaded <= 1'b1;
      end else if (bus.mem_cs && bus.mem_w) begin
         mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      end
   end
   assign bus.mem_rdata  = mem[bus.mem_addr[7:0]];
   assign bus1.mem_rdata = 32'h0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_cpu(input logic cs, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
      bus.cpu_cs = cs; bus.cpu_r = r; bus.cpu_w = w;
      bus.cpu_addr = a; bus.cpu_wdata = d;
   endtask

   task automatic set_dma(input logic req, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
      bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
   endtask

   task automatic do_reset;
      set_cpu(0, 0, 0, 0, 0);
      set_dma(0, 0, 0, 0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      set_cpu(1, 1, 0, 32'h0, 32'h0);
      set_dma(1, 1, 32'h0, 32'hFFFF_FFFF);
      @(negedge clk);
      n_total++; if (bus.mem_cs !== 1'b0) $display("FAIL reset_mem_cs: got %b want 0", bus.mem_cs); else n_pass++;
      n_total++; if (bus.mem_w !== 1'b0) $display("FAIL reset_mem_w: got %b want 0", bus.mem_w); else n_pass++;
      n_total++; if (bus.dma_ack !== 1'b0) $display("FAIL reset_dma_ack: got %b want 0", bus.dma_ack); else n_pass++;
      n_total++; if (bus.cpu_stall !== 1'b0) $display("FAIL reset_cpu_stall: got %b want 0", bus.cpu_stall); else n_pass++;
      n_total++; if (bus.cpu_rdata !== 32'h0) $display("FAIL reset_cpu_rdata: got %h want 0", bus.cpu_rdata); else n_pass++;
      n_total++; if (bus.dma_rdata !== 32'h0) $display("FAIL reset_dma_rdata: got %h want 0", bus.dma_rdata); else n_pass++;
      tick();
      do_reset();
      tick();
      n_total++; if (mem[0] !== 32'hC0DE_0000) $display("FAIL reset_no_write: got %h want c0de0000", mem[0]); else n_pass++;
   endtask

   task automatic test_cpu_only;
      set_cpu(1, 0, 1, 32'h10, 32'hDEAD_BEEF);
      @(negedge clk);
      n_total++; if (bus.cpu_stall !== 1'b0) $display("FAIL cpu_wr_stall: got %b want 0", bus.cpu_stall); else n_pass++;
      n_total++; if ({bus.mem_cs, bus.mem_r, bus.mem_w} !== 3'b101) $display("FAIL cpu_wr_ctl: got %b want 101", {bus.mem_cs, bus.mem_r, bus.mem_w}); else n_pass++;
      n_total++; if (bus.mem_addr !== 32'h10) $display("FAIL cpu_wr_addr: got %h want 10", bus.mem_addr); else n_pass++;
      tick();
      set_cpu(1, 1, 0, 32'h10, 32'h0);
      @(negedge clk);
      n_total++; if (bus.cpu_stall !== 1'b0) $display("FAIL cpu_rd_stall: got %b want 0", bus.cpu_stall); else n_pass++;
      n_total++; if (bus.cpu_rdata !== 32'hDEAD_BEEF) $display("FAIL cpu_rd_data: got %h want deadbeef", bus.cpu_rdata); else n_pass++;
      n_total++; if (bus.dma_rdata !== 32'h0) $display("FAIL cpu_rd_dma_rdata: got %h want 0", bus.dma_rdata); else n_pass++;
      tick();
      set_cpu(0, 0, 0, 0, 0);
   endtask

   task automatic test_dma_only;
      set_dma(1, 1, 32'h20, 32'h1234_5678);
      @(negedge clk);
      n_total++; if (bus.dma_ack !== 1'b1) $display("FAIL dma_wr_ack: got %b want 1", bus.dma_ack); else n_pass++;
      n_total++; if ({bus.mem_cs, bus.mem_r, bus.mem_w} !== 3'b101) $display("FAIL dma_wr_ctl: got %b want 101", {bus.mem_cs, bus.mem_r, bus.mem_w}); else n_pass++;
      n_total++; if (bus.mem_wdata !== 32'h1234_5678) $display("FAIL dma_wr_wdata: got %h want 12345678", bus.mem_wdata); else n_pass++;
      tick();
      set_dma(1, 0, 32'h20, 32'h0);
      @(negedge clk);
      n_total++; if (bus.dma_ack !== 1'b1) $display("FAIL dma_rd_ack: got %b want 1", bus.dma_ack); else n_pass++;
      n_total++; if (bus.mem_r !== 1'b1) $display("FAIL dma_rd_mem_r: got %b want 1", bus.mem_r); else n_pass++;
      n_total++; if (bus.dma_rdata !== 32'h1234_5678) $display("FAIL dma_rd_data: got %h want 12345678", bus.dma_rdata); else n_pass++;
      n_total++; if (bus.cpu_rdata !== 32'h0) $display("FAIL dma_rd_cpu_rdata: got %h want 0", bus.cpu_rdata); else n_pass++;
      tick();
      set_dma(0, 0, 0, 0);
   endtask

   task automatic test_contention;
      logic exp_dma;
      do_reset();
      set_cpu(1, 1, 0, 32'h10, 32'h0);
      set_dma(1, 0, 32'h20, 32'h0);
      for (int c = 0; c < 16; c++) begin
         exp_dma = ((c / 4) % 2) == 1;
         @(negedge clk);
         n_total++; if (bus.dma_ack !== exp_dma) $display("FAIL cont_ack c%0d: got %b want %b", c, bus.dma_ack, exp_dma); else n_pass++;
         n_total++; if (bus.cpu_stall !== exp_dma) $display("FAIL cont_stall c%0d: got %b want %b", c, bus.cpu_stall, exp_dma); else n_pass++;
         n_total++; if (bus.cpu_rdata !== (exp_dma ? 32'h0 : 32'hDEAD_BEEF)) $display("FAIL cont_cpu_rdata c%0d: got %h", c, bus.cpu_rdata); else n_pass++;
         n_total++; if (bus.dma_rdata !== (exp_dma ? 32'h1234_5678 : 32'h0)) $display("FAIL cont_dma_rdata c%0d: got %h", c, bus.dma_rdata); else n_pass++;
         tick();
      end
      do_reset();
   endtask

   task automatic test_early_end;
      logic exp_dma;
      do_reset();
      set_cpu(1, 1, 0, 32'h10, 32'h0);
      set_dma(1, 0, 32'h20, 32'h0);
      // cycles 0-3 CPU, 4-5 forced DMA, 6 DMA drops, 7-10 CPU, 11 DMA again
      for (int c = 0; c < 12; c++) begin
         bus.dma_req = (c != 6);
         exp_dma = (c == 4) || (c == 5) || (c == 11);
         @(negedge clk);
         n_total++; if (bus.dma_ack !== exp_dma) $display("FAIL early_ack c%0d: got %b want %b", c, bus.dma_ack, exp_dma); else n_pass++;
         n_total++; if (bus.cpu_stall !== exp_dma) $display("FAIL early_stall c%0d: got %b want %b", c, bus.cpu_stall, exp_dma); else n_pass++;
         if (c == 6) begin
            n_total++; if (bus.mem_addr !== 32'h10) $display("FAIL early_cpu_addr: got %h want 10", bus.mem_addr); else n_pass++;
            n_total++; if (bus.cpu_rdata !== 32'hDEAD_BEEF) $display("FAIL early_cpu_rdata: got %h want deadbeef", bus.cpu_rdata); else n_pass++;
         end
         tick();
      end
      do_reset();
   endtask

   task automatic test_reset_mid_burst;
      do_reset();
      set_cpu(1, 1, 0, 32'h10, 32'h0);
      set_dma(1, 1, 32'h30, 32'h1111_1111);
      for (int c = 0; c < 4; c++) tick();
      @(negedge clk);
      n_total++; if ({bus.dma_ack, bus.mem_w} !== 2'b11) $display("FAIL rmb_first_ack: got %b want 11", {bus.dma_ack, bus.mem_w}); else n_pass++;
      tick();
      reset = 1'b0;
      set_dma(1, 1, 32'h34, 32'h2222_2222);
      @(negedge clk);
      n_total++; if (bus.mem_cs !== 1'b0) $display("FAIL rmb_mem_cs: got %b want 0", bus.mem_cs); else n_pass++;
      n_total++; if (bus.dma_ack !== 1'b0) $display("FAIL rmb_ack: got %b want 0", bus.dma_ack); else n_pass++;
      n_total++; if (bus.cpu_stall !== 1'b0) $display("FAIL rmb_stall: got %b want 0", bus.cpu_stall); else n_pass++;
      n_total++; if (bus.mem_w !== 1'b0) $display("FAIL rmb_mem_w: got %b want 0", bus.mem_w); else n_pass++;
      tick();
      reset = 1'b1;
      @(negedge clk);
      n_total++; if ({bus.dma_ack, bus.cpu_stall} !== 2'b00) $display("FAIL rmb_after_gnt: got %b want 00", {bus.dma_ack, bus.cpu_stall}); else n_pass++;
      n_total++; if (bus.mem_addr !== 32'h10) $display("FAIL rmb_after_addr: got %h want 10", bus.mem_addr); else n_pass++;
      tick();
      n_total++; if (mem[8'h34] !== 32'hC0DE_0034) $display("FAIL rmb_no_commit: got %h want c0de0034", mem[8'h34]); else n_pass++;
      n_total++; if (mem[8'h30] !== 32'h1111_1111) $display("FAIL rmb_first_commit: got %h want 11111111", mem[8'h30]); else n_pass++;
      do_reset();
   endtask

   task automatic test_idle;
      set_cpu(0, 0, 0, 32'h10, 32'hFFFF_FFFF);
      set_dma(0, 1, 32'h20, 32'hFFFF_FFFF);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_total++; if ({bus.mem_cs, bus.mem_w} !== 2'b00) $display("FAIL idle_ctl c%0d: got %b want 00", c, {bus.mem_cs, bus.mem_w}); else n_pass++;
         tick();
      end
      n_total++; if (mem[8'h10] !== 32'hDEAD_BEEF) $display("FAIL idle_mem10: got %h want deadbeef", mem[8'h10]); else n_pass++;
      n_total++; if (mem[8'h20] !== 32'h1234_5678) $display("FAIL idle_mem20: got %h want 12345678", mem[8'h20]); else n_pass++;
   endtask

   task automatic test_rw_both;
      set_dma(0, 0, 0, 0);
      set_cpu(1, 1, 1, 32'h40, 32'h55AA_55AA);
      @(negedge clk);
      n_total++; if ({bus.mem_cs, bus.mem_r, bus.mem_w} !== 3'b111) $display("FAIL rw_ctl: got %b want 111", {bus.mem_cs, bus.mem_r, bus.mem_w}); else n_pass++;
      n_total++; if (bus.cpu_stall !== 1'b0) $display("FAIL rw_stall: got %b want 0", bus.cpu_stall); else n_pass++;
      n_total++; if (bus.cpu_rdata !== 32'hC0DE_0040) $display("FAIL rw_rdata: got %h want c0de0040", bus.cpu_rdata); else n_pass++;
      tick();
      n_total++; if (mem[8'h40] !== 32'h55AA_55AA) $display("FAIL rw_commit: got %h want 55aa55aa", mem[8'h40]); else n_pass++;
      set_cpu(0, 0, 0, 0, 0);
   endtask

   task automatic test_burst1;
      logic exp_dma;
      bus1.cpu_cs = 1'b1; bus1.cpu_r = 1'b1; bus1.cpu_w = 1'b0;
      bus1.cpu_addr = 32'h100; bus1.cpu_wdata = 32'h0;
      bus1.dma_req = 1'b1; bus1.dma_we = 1'b0;
      bus1.dma_addr = 32'h200; bus1.dma_wdata = 32'h0;
      // MAX_WAIT=2, BURST=1: CPU, CPU, DMA repeating
      for (int c = 0; c < 9; c++) begin
         exp_dma = (c % 3) == 2;
         @(negedge clk);
         n_total++; if (bus1.dma_ack !== exp_dma) $display("FAIL b1_ack c%0d: got %b want %b", c, bus1.dma_ack, exp_dma); else n_pass++;
         n_total++; if (bus1.cpu_stall !== exp_dma) $display("FAIL b1_stall c%0d: got %b want %b", c, bus1.cpu_stall, exp_dma); else n_pass++;
         n_total++; if (bus1.mem_addr !== (exp_dma ? 32'h200 : 32'h100)) $display("FAIL b1_addr c%0d: got %h", c, bus1.mem_addr); else n_pass++;
         tick();
      end
      bus1.cpu_cs = 1'b0; bus1.dma_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_pass  = 0;
      n_total = 0;
      reset   = 1'b0;
      set_cpu(0, 0, 0, 0, 0);
      set_dma(0, 0, 0, 0);
      bus1.cpu_cs = 1'b0; bus1.cpu_r = 1'b0; bus1.cpu_w = 1'b0;
      bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
      bus1.dma_req = 1'b0; bus1.dma_we = 1'b0;
      bus1.dma_addr = '0; bus1.dma_wdata = '0;
      tick();
      tick();
      test_reset();
      test_cpu_only();
      test_dma_only();
      test_contention();
      test_early_end();
      test_reset_mid_burst();
      test_idle();
      test_rw_both();
      test_burst1();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (dmem) between two requesters: the CPU data port and a DMA/debug port.
- Sits between the cpu, the DMA engine and dmem inside the top-level dataflow wrapper.
- CPU has priority; a starvation counter and bounded DMA bursts guarantee DMA progress.
- A stall output freezes the CPU (PC hold) on cycles when it loses the memory.

Parameters:
ADDR_W, 32, address width of both requesters and memory
DATA_W, 32, data width
MAX_WAIT, 4, consecutive cycles DMA may be blocked by CPU before forced grant (1..15)
BURST, 4, max consecutive DMA accesses per forced grant (1..15)

Ports:
clk_in  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
cpu_cs  input  1  CPU memory request
cpu_r  input  1  CPU read
cpu_w  input  1  CPU write
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_rdata  output  DATA_W  read data to CPU
cpu_stall  output  1  CPU must hold request and PC this cycle
dma_req  input  1  DMA request, held until dma_ack
dma_we  input  1  1 = write, 0 = read
dma_addr  input  ADDR_W  DMA address
dma_wdata  input  DATA_W  DMA write data
dma_rdata  output  DATA_W  read data to DMA
dma_ack  output  1  DMA access performed this cycle
mem_cs  output  1  dmem chip select
mem_r  output  1  dmem read
mem_w  output  1  dmem write
mem_addr  output  ADDR_W  dmem address
mem_wdata  output  DATA_W  dmem write data
mem_rdata  input  DATA_W  dmem read data (combinational)

Behaviour:
- Timing: one access per cycle; grant is combinational from current requests and registered state; state updates on clk_in rising edge.
  - Read data is valid in the grant cycle (dmem read is combinational).
  - Writes commit at the edge ending the grant cycle.
- Registered state: mode {CPU_PRI, DMA_BURST}, wait_cnt (4 bit), burst_cnt (4 bit).
- Reset (reset==0 at edge): mode=CPU_PRI, wait_cnt=0, burst_cnt=0.
  - While reset==0, all outputs are forced idle: mem_cs/mem_r/mem_w=0, cpu_stall=0, dma_ack=0, rdata outputs=0.
  - Reset mid-burst aborts the burst; no ack is issued.
- Routing:
  - Granted requester drives mem_addr/mem_wdata/mem_r/mem_w; mem_cs=1.
  - DMA grant: mem_r=~dma_we, mem_w=dma_we.
  - No grant: mem_cs=mem_r=mem_w=0, mem_addr/mem_wdata=0.
  - cpu_rdata=mem_rdata when CPU granted, else 0; dma_rdata likewise.
- CPU_PRI mode:
  - cpu_cs & ~dma_req: grant CPU; wait_cnt=0.
  - ~cpu_cs & dma_req: grant DMA, dma_ack=1; wait_cnt=0; stay CPU_PRI.
  - Both requesting, wait_cnt<MAX_WAIT: grant CPU; wait_cnt++.
  - Both requesting, wait_cnt==MAX_WAIT: grant DMA, dma_ack=1, cpu_stall=1; next mode=DMA_BURST, burst_cnt=1, wait_cnt=0.
  - Neither requesting: idle, wait_cnt=0.
- DMA_BURST mode:
  - dma_req & burst_cnt<BURST: grant DMA, dma_ack=1, cpu_stall=cpu_cs; burst_cnt++.
  - ~dma_req or burst_cnt==BURST: behave as CPU_PRI with wait_cnt=0 this cycle; next mode=CPU_PRI, burst_cnt=0.
- cpu_stall is only ever 1 when cpu_cs=1 and DMA is granted.
- Invariants: never more than one grant per cycle; no mem_w without mem_cs.
- Boundary cases:
  - BURST=1: a forced grant yields exactly one DMA access, then back to CPU_PRI.
  - cpu_r & cpu_w both 1: both passed through unchanged; no arbitration effect.

Test Plan:
- CPU only: cpu_cs=1, cpu_w=1, addr 0x10, data 0xDEADBEEF, then read 0x10 -> cpu_stall=0 both cycles; cpu_rdata=0xDEADBEEF.
- DMA only: dma_req=1, dma_we=1, addr 0x20, data 0x12345678 -> dma_ack=1 same cycle; subsequent DMA read returns 0x12345678.
- Contention, MAX_WAIT=4, BURST=4: cpu_cs and dma_req held continuously -> CPU granted cycles 0-3, DMA granted cycles 4-7 with cpu_stall=1, CPU granted cycles 8-11, DMA granted cycles 12-15.
- Early burst end: forced DMA grant, dma_req drops after 2 acks -> cycle after last ack cpu_stall=0, CPU granted, mode back to CPU_PRI, wait_cnt=0.
- Reset mid-burst: reset=0 during 2nd DMA burst cycle -> that cycle mem_cs=0, dma_ack=0, cpu_stall=0, no write committed; after release, CPU wins the first contention cycle.
- Idle: no requests for 10 cycles -> mem_cs=mem_w=0 throughout; dmem contents unchanged.
